// File: rtl/weather_pkg.sv
// Shared widths, FSM state type, feature-frame layout and quantiser saturation for the
// weather classifier front end.
package weather_pkg;

    localparam int FEAT_W = 4;
    localparam int RAW_W  = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        QUANT = 1'b1
    } state_t;

    // Field order matches the classifier's in_temp_max/in_temp_min/in_precipitation/in_wind.
    typedef struct packed {
        logic [FEAT_W-1:0] temp_max;
        logic [FEAT_W-1:0] temp_min;
        logic [FEAT_W-1:0] precip;
        logic [FEAT_W-1:0] wind;
    } feat_frame_t;

    function automatic logic [FEAT_W-1:0] sat15(input logic [15:0] x);
        return (x > 16'd15) ? 4'd15 : x[FEAT_W-1:0];
    endfunction

endpackage

// File: rtl/weather_window_accum.sv
// Per-window running statistics: sample index, temperature max/min and precipitation/wind
// sums, with a combinational pulse on the accept that completes the window.
module weather_window_accum
    import weather_pkg::*;
#(
    parameter int WINDOW = 8,
    localparam int CNT_W = $clog2(WINDOW),
    localparam int SUM_W = RAW_W + CNT_W
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             accept,
    input  logic [RAW_W-1:0] temp,
    input  logic [RAW_W-1:0] precip,
    input  logic [RAW_W-1:0] wind,
    output logic [RAW_W-1:0] tmax,
    output logic [RAW_W-1:0] tmin,
    output logic [SUM_W-1:0] psum,
    output logic [SUM_W-1:0] wsum,
    output logic             window_done
);

    logic [CNT_W-1:0] count;
    logic             first;

    assign first       = (count == '0);
    assign window_done = accept && (count == CNT_W'(WINDOW - 1));

    // NOTE: the statistics registers sit on the asynchronous reset on purpose: they are a
    // handful of flops, not a memory, and a reset must leave no trace of a partial window.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            count <= '0;
            tmax  <= '0;
            tmin  <= '0;
            psum  <= '0;
            wsum  <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            count <= window_done ? '0 : count + CNT_W'(1);
            if (first) begin
                tmax <= temp;
                tmin <= temp;
                psum <= SUM_W'(precip);
                wsum <= SUM_W'(wind);
            end else begin
                if (temp > tmax) tmax <= temp;
                if (temp < tmin) tmin <= temp;
                psum <= psum + SUM_W'(precip);
                wsum <= wsum + SUM_W'(wind);
            end
        end
    end

endmodule

// File: rtl/weather_feature_builder.sv
// Reduces WINDOW raw sensor samples to one quantised 4-feature frame on a valid/ready slot.
// Define WEATHER_FB_OVERLAP_EN to accumulate the next window while a frame waits in the slot.
module weather_feature_builder
    import weather_pkg::*;
#(
    parameter int WINDOW       = 8,
    parameter int TEMP_SHIFT   = 2,
    parameter int PRECIP_SHIFT = 3,
    parameter int WIND_SHIFT   = 3
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              smp_valid,
    output logic              smp_ready,
    input  logic [RAW_W-1:0]  smp_temp,
    input  logic [RAW_W-1:0]  smp_precip,
    input  logic [RAW_W-1:0]  smp_wind,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic [FEAT_W-1:0] feat_temp_max,
    output logic [FEAT_W-1:0] feat_temp_min,
    output logic [FEAT_W-1:0] feat_precip,
    output logic [FEAT_W-1:0] feat_wind
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam int SUM_W = RAW_W + CNT_W;

    state_t           state;
    feat_frame_t      slot;
    feat_frame_t      quant;
    logic             slot_ok;
    logic             accept;
    logic             window_done;
    logic             handoff;
    logic             load;
    logic [RAW_W-1:0] tmax;
    logic [RAW_W-1:0] tmin;
    logic [SUM_W-1:0] psum;
    logic [SUM_W-1:0] wsum;

`ifdef WEATHER_FB_OVERLAP_EN
    assign slot_ok = 1'b1;
`else
    assign slot_ok = !feat_valid;
`endif

    assign smp_ready = (state == ACCUM) && slot_ok;
    assign accept    = smp_valid && smp_ready;
    assign handoff   = feat_valid && feat_ready;
    // The slot can take a new frame if it is empty or is being emptied on this edge.
    assign load      = (state == QUANT) && (!feat_valid || feat_ready);

    weather_window_accum #(
        .WINDOW (WINDOW)
    ) u_accum (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .accept      (accept),
        .temp        (smp_temp),
        .precip      (smp_precip),
        .wind        (smp_wind),
        .tmax        (tmax),
        .tmin        (tmin),
        .psum        (psum),
        .wsum        (wsum),
        .window_done (window_done)
    );

    always_comb begin
        // NOTE: default the whole struct first so no path through this block infers a latch.
        quant          = '0;
        quant.temp_max = sat15(16'(tmax >> TEMP_SHIFT));
        quant.temp_min = sat15(16'(tmin >> TEMP_SHIFT));
        quant.precip   = sat15(16'(psum >> PRECIP_SHIFT));
        quant.wind     = sat15(16'((wsum >> CNT_W) >> WIND_SHIFT));
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            case (state)
                ACCUM:   if (window_done) state <= QUANT;
                QUANT:   if (load)        state <= ACCUM;
                default:                  state <= ACCUM;
            endcase
        end
    end

    // A reload on the handoff edge keeps feat_valid high with the new frame.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            feat_valid <= 1'b0;
            slot       <= '0;
        end else if (load) begin
            feat_valid <= 1'b1;
            slot       <= quant;
        end else if (handoff) begin
            feat_valid <= 1'b0;
        end
    end

    assign feat_temp_max = slot.temp_max;
    assign feat_temp_min = slot.temp_min;
    assign feat_precip   = slot.precip;
    assign feat_wind     = slot.wind;

endmodule
